rs422_echo_top: RTL and testbench

- RS-422 UART echo block: receives 8N1 bytes on `rxd`, retransmits each valid byte on `txd`, pulses `send_over` when each transmission completes.
- Sits at the FPGA top level between the RS-422 transceiver pins and the `clk59m` domain.
- Contains a receiver, a one-byte holding register and a transmitter, all sharing one baud divisor.

---
 rtl/rs422_pkg.sv | 15 +
 rtl/rs422_uart_rx.sv | 149 ++++++++++++++
 rtl/rs422_echo_top.sv | 158 +++++++++++++++
 tb/tb_rs422_echo_top.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rs422_pkg.sv
// rtl/rs422_pkg.sv - shared UART states and frame constants for the RS-422 echo block
package rs422_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/rs422_uart_rx.sv
// rtl/rs422_uart_rx.sv - 8N1 receiver: synchroniser, start detect, mid-bit sampling
// Optional even parity check when PARITY_EN is defined.
module rs422_uart_rx
  import rs422_pkg::*;
#(
  parameter int CLKS_PER_BIT = 667,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk59m,
  input  logic                 rst,
  input  logic                 i_rxd,
  output logic                 o_rx_valid,
  output logic [DATA_BITS-1:0] o_rx_data
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  uart_state_t            r_state, w_state_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [2:0]             r_bit_idx, w_bit_idx_nxt;
  logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
  logic                   r_wait_high, w_wait_high_nxt;
  logic                   r_valid, w_valid_nxt;
  logic                   w_rx;
  logic                   w_frame_ok;

  assign w_rx       = r_sync[SYNC_STAGES-1];
  assign o_rx_valid = r_valid;
  assign o_rx_data  = r_shift;

`ifdef PARITY_EN
  logic r_bad, w_bad_nxt;
  assign w_frame_ok = !r_bad;
`else
  assign w_frame_ok = 1'b1;
`endif

  always_ff @(posedge clk59m) begin
    if (rst) begin
      r_sync      <= {SYNC_STAGES{IDLE_LEVEL}};
      r_prev      <= IDLE_LEVEL;
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_wait_high <= 1'b0;
      r_valid     <= 1'b0;
`ifdef PARITY_EN
      r_bad       <= 1'b0;
`endif
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], i_rxd};
      r_prev      <= w_rx;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_wait_high <= w_wait_high_nxt;
      r_valid     <= w_valid_nxt;
`ifdef PARITY_EN
      r_bad       <= w_bad_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_bit_idx_nxt   = r_bit_idx;
    w_shift_nxt     = r_shift;
    w_wait_high_nxt = r_wait_high;
    w_valid_nxt     = 1'b0;
`ifdef PARITY_EN
    w_bad_nxt       = r_bad;
`endif
    case (r_state)
      IDLE: begin
        if (r_prev && !w_rx) begin
          w_state_nxt = START;
          w_cnt_nxt   = '0;
`ifdef PARITY_EN
          w_bad_nxt   = 1'b0;
`endif
        end
      end
      START: begin
        // A start bit that is high again at its middle was only a glitch.
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = w_rx ? IDLE : DATA;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt     = '0;
          w_shift_nxt   = {w_rx, r_shift[DATA_BITS-1:1]};
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_bad_nxt   = (w_rx != ^r_shift);
          w_state_nxt = STOP;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
`endif
      STOP: begin
        if (r_wait_high) begin
          if (w_rx) begin
            w_wait_high_nxt = 1'b0;
            w_state_nxt     = IDLE;
          end
        end else if (r_cnt == BIT_LAST) begin
          w_cnt_nxt = '0;
          if (!w_rx) begin
            w_wait_high_nxt = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_valid_nxt = w_frame_ok;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/rs422_echo_top.sv
// rtl/rs422_echo_top.sv - RS-422 echo: receiver, one-byte holding register, transmitter
// Even parity bit is appended when PARITY_EN is defined.
module rs422_echo_top
  import rs422_pkg::*;
#(
  parameter int CLKS_PER_BIT = 667,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk59m,
  input  logic rst,
  input  logic rxd,
  output logic txd,
  output logic send_over
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] SO_CNT   = CW'(CLKS_PER_BIT - 2);

  logic                 w_rx_valid;
  logic [DATA_BITS-1:0] w_rx_data;
  logic [DATA_BITS-1:0] r_hold;
  logic                 r_hold_full;
  logic                 w_take;
  logic                 w_bit_end;

  uart_state_t          r_tx_state, w_tx_state_nxt;
  logic [CW-1:0]        r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]           r_tx_idx, w_tx_idx_nxt;
  logic [DATA_BITS-1:0] r_tx_data, w_tx_data_nxt;
  logic                 r_txd, w_txd_nxt;
  logic                 r_send_over, w_send_over_nxt;

  rs422_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clk59m    (clk59m),
    .rst       (rst),
    .i_rxd     (rxd),
    .o_rx_valid(w_rx_valid),
    .o_rx_data (w_rx_data)
  );

  assign txd       = r_txd;
  assign send_over = r_send_over;
  assign w_bit_end = (r_tx_cnt == BIT_LAST);

  // Taking straight out of the last stop-bit cycle keeps back-to-back frames gapless.
  assign w_take = r_hold_full &&
                  ((r_tx_state == IDLE) || ((r_tx_state == STOP) && w_bit_end));

  always_ff @(posedge clk59m) begin
    if (rst) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_rx_valid && (!r_hold_full || w_take)) begin
      r_hold      <= w_rx_data;
      r_hold_full <= 1'b1;
    end else if (w_take) begin
      r_hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk59m) begin
    if (rst) begin
      r_tx_state  <= IDLE;
      r_tx_cnt    <= '0;
      r_tx_idx    <= '0;
      r_tx_data   <= '0;
      r_txd       <= IDLE_LEVEL;
      r_send_over <= 1'b0;
    end else begin
      r_tx_state  <= w_tx_state_nxt;
      r_tx_cnt    <= w_tx_cnt_nxt;
      r_tx_idx    <= w_tx_idx_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_txd       <= w_txd_nxt;
      r_send_over <= w_send_over_nxt;
    end
  end

  always_comb begin
    w_tx_state_nxt  = r_tx_state;
    w_tx_cnt_nxt    = r_tx_cnt;
    w_tx_idx_nxt    = r_tx_idx;
    w_tx_data_nxt   = r_tx_data;
    w_txd_nxt       = r_txd;
    w_send_over_nxt = 1'b0;
    case (r_tx_state)
      IDLE: begin
        if (w_take) begin
          w_tx_state_nxt = START;
          w_tx_cnt_nxt   = '0;
          w_tx_data_nxt  = r_hold;
          w_txd_nxt      = 1'b0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_tx_cnt_nxt   = '0;
          w_tx_idx_nxt   = '0;
          w_txd_nxt      = r_tx_data[0];
          w_tx_state_nxt = DATA;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CW'(1);
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_tx_cnt_nxt = '0;
          if (r_tx_idx == 3'(DATA_BITS - 1)) begin
`ifdef PARITY_EN
            w_tx_state_nxt = PARITY;
            w_txd_nxt      = ^r_tx_data;
`else
            w_tx_state_nxt = STOP;
            w_txd_nxt      = IDLE_LEVEL;
`endif
          end else begin
            w_tx_idx_nxt = r_tx_idx + 3'd1;
            w_txd_nxt    = r_tx_data[r_tx_idx + 3'd1];
          end
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CW'(1);
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = STOP;
          w_txd_nxt      = IDLE_LEVEL;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CW'(1);
        end
      end
`endif
      STOP: begin
        if (w_bit_end) begin
          w_tx_cnt_nxt = '0;
          if (w_take) begin
            w_tx_state_nxt = START;
            w_tx_data_nxt  = r_hold;
            w_txd_nxt      = 1'b0;
          end else begin
            w_tx_state_nxt = IDLE;
          end
        end else begin
          w_tx_cnt_nxt    = r_tx_cnt + CW'(1);
          w_send_over_nxt = (r_tx_cnt == SO_CNT);
        end
      end
      default: w_tx_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rs422_echo_top.sv
// tb/tb_rs422_echo_top.sv - directed scoreboard bench for the RS-422 echo block
`timescale 1ns/1ps
module tb_rs422_echo_top;

  localparam int CPB  = 667;
  localparam int SYNC = 2;
  localparam int HALF = CPB / 2;
  // rxd start-bit drive cycle to txd start-bit cycle: sync chain, edge detect,
  // half bit, 9 full bits to the stop sample, rx_valid, hold load, take.
  localparam int LAT  = SYNC + 1 + HALF + 9 * CPB + 2;

  typedef struct packed {
    logic [7:0] data;
    int         fall;
  } exp_t;

  logic clk59m;
  logic rst;
  logic rxd;
  logic txd;
  logic send_over;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   frames_seen = 0;
  int   aborted = 0;
  int   so_cycles = 0;
  logic mon_abort = 1'b0;
  logic mon_busy = 1'b0;
  exp_t sb_q[$];

  rs422_echo_top #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk59m   (clk59m),
    .rst      (rst),
    .rxd      (rxd),
    .txd      (txd),
    .send_over(send_over)
  );

  initial clk59m = 1'b0;
  always #5 clk59m = ~clk59m;

  always @(posedge clk59m) cyc <= cyc + 1;
  always @(negedge clk59m) if (send_over === 1'b1) so_cycles <= so_cycles + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk59m);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk59m);
      #1;
    end
  endtask

  task automatic watch_idle(input int n, output int bad);
    bad = 0;
    repeat (n) begin
      @(negedge clk59m);
      if (txd !== 1'b1 || send_over !== 1'b0) bad++;
    end
    @(posedge clk59m);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic echo);
    exp_t e;
    if (echo) begin
      e.data = b;
      e.fall = cyc + LAT;
      sb_q.push_back(e);
    end
    rxd = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cycles(CPB);
    end
    rxd = stop_bit;
    wait_cycles(CPB);
    rxd = 1'b1;
  endtask

  task automatic mon_wait(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk59m);
      if (rst) mon_abort = 1'b1;
    end
  endtask

  // Decodes every frame on txd at mid-bit and scores it against the queue.
  initial begin : monitor
    exp_t       e;
    logic [7:0] d;
    logic       st, sp, so;
    int         fall;
    forever begin
      @(negedge clk59m);
      if (!rst && txd === 1'b0) begin
        mon_busy  = 1'b1;
        mon_abort = 1'b0;
        fall      = cyc;
        mon_wait(HALF);
        st = txd;
        for (int i = 0; i < 8; i++) begin
          mon_wait(CPB);
          d[i] = txd;
        end
        mon_wait(CPB);
        sp = txd;
        mon_wait(CPB - HALF - 1);
        so = send_over;
        check("frame_expected", (sb_q.size() > 0), 1);
        e = '0;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        if (mon_abort) begin
          aborted++;
        end else begin
          frames_seen++;
          check("tx_start_bit", st, 1'b0);
          check("tx_data", d, e.data);
          check("tx_fall_cycle", fall, e.fall);
          check("tx_stop_bit", sp, 1'b1);
          check("send_over_last_stop_cycle", so, 1'b1);
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : stimulus
    int bad;
    int t_end;
    int t_rst;
    rst = 1'b1;
    rxd = 1'b1;

    // Reset and idle line
    @(posedge clk59m);
    #1;
    watch_idle(20, bad);
    check("reset_idle_outputs", bad, 0);
    rst = 1'b0;
    watch_idle(1000, bad);
    check("post_reset_idle", bad, 0);

    // Single byte 0x59
    t_end = cyc + LAT + 10 * CPB + 5;
    send_byte(8'h59, 1'b1, 1'b1);
    wait_until(t_end);
    check("p2_frames", frames_seen, 1);
    check("p2_send_over_cycles", so_cycles, 1);
    check("p2_queue_empty", sb_q.size(), 0);

    // Back-to-back 0xBA, 0x65
    send_byte(8'hBA, 1'b1, 1'b1);
    t_end = cyc + LAT + 10 * CPB + 5;
    send_byte(8'h65, 1'b1, 1'b1);
    wait_until(t_end);
    check("p3_frames", frames_seen, 3);
    check("p3_send_over_cycles", so_cycles, 3);
    check("p3_queue_empty", sb_q.size(), 0);

    // Framing error then a valid byte
    send_byte(8'h65, 1'b0, 1'b0);
    wait_cycles(CPB);
    t_end = cyc + LAT + 10 * CPB + 5;
    send_byte(8'h11, 1'b1, 1'b1);
    wait_until(t_end);
    check("p4_frames", frames_seen, 4);
    check("p4_send_over_cycles", so_cycles, 4);
    check("p4_queue_empty", sb_q.size(), 0);

    // 100-cycle glitch on idle line
    rxd = 1'b0;
    wait_cycles(100);
    rxd = 1'b1;
    watch_idle(3 * CPB, bad);
    check("p5_glitch_idle", bad, 0);
    check("p5_frames", frames_seen, 4);

    // Reset during the 4th transmitted data bit of 0x59
    t_rst = cyc + LAT + 4 * CPB + HALF;
    send_byte(8'h59, 1'b1, 1'b1);
    wait_until(t_rst);
    check("p6_tx_active", mon_busy, 1'b1);
    rst = 1'b1;
    @(posedge clk59m);
    @(negedge clk59m);
    check("p6_txd_after_rst", txd, 1'b1);
    check("p6_send_over_after_rst", send_over, 1'b0);
    wait_cycles(4);
    rst = 1'b0;
    watch_idle(11 * CPB, bad);
    check("p6_no_resume", bad, 0);
    check("p6_aborted", aborted, 1);
    check("p6_frames", frames_seen, 4);
    check("p6_send_over_cycles", so_cycles, 4);
    check("p6_queue_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
